clk_gen_multi: RTL and testbench
================================

Name: clk_gen_multi

Overview:
- Synthesizable, multi-channel successor to the behavioural clock generator.
- Derives NUM_CH gated, divided clock-enable waveforms from one system clock.
- Period, duty (high count) and phase offset are runtime-programmable per channel.
- Provides glitch-free start/stop and boundary-aligned reconfiguration. Outputs feed downstream timing/strobe logic; they are not used as a clock net.

Parameters:
- NUM_CH, 2, number of independent output channels (1..16).
- CNT_W, 8, width of the period/high/phase counters; max period 2^CNT_W-1 cycles.
- CH_W, $clog2(NUM_CH) (min 1), width of the channel select.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- en  input  NUM_CH  per-channel run request, level-sensitive.
- cfg_wr  input  1  one-cycle config write strobe.
- cfg_ch  input  CH_W  target channel for cfg_wr.
- cfg_period  input  CNT_W  period in clk cycles.
- cfg_high  input  CNT_W  cycles high per period (duty).
- cfg_phase  input  CNT_W  start delay in clk cycles after en rise.
- cfg_err  output  1  one-cycle pulse: last cfg_wr rejected.
- clk_out  output  NUM_CH  generated waveforms, registered.
- active  output  NUM_CH  channel in PHASE_WAIT, RUN or DRAIN.

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset values:
  - clk_out=0, active=0, cfg_err=0.
  - All channels in IDLE.
  - Active config: period=2, high=1, phase=0. Shadow config equals active config; pending=0.
- Config write (cfg_wr=1):
  - Reject if cfg_period==0, cfg_phase>=cfg_period, or cfg_ch>=NUM_CH. On reject: cfg_err=1 next cycle, no state change.
  - Otherwise load the shadow registers of cfg_ch and set pending.
  - Pending shadow is copied to active config only when the channel is IDLE, or at a period boundary in RUN (cnt wraps to 0). Never mid-period.
  - A second write before the copy overwrites the shadow; last write wins.
- Per-channel FSM. cnt is CNT_W bits, runs 0..period-1.
  - IDLE: clk_out=0, cnt=0. Apply pending config. If en=1: go to PHASE_WAIT when phase>0 (ph_cnt=phase-1), else go to RUN with cnt=0.
  - PHASE_WAIT: clk_out=0. Decrement ph_cnt; when ph_cnt==0, go to RUN with cnt=0. If en drops, return to IDLE immediately.
  - RUN: clk_out registered as (cnt<high).
    - cnt increments each cycle; at period-1 it wraps to 0 (boundary), and pending config is applied there.
    - If en=0 is sampled, go to DRAIN (no truncated high pulse).
  - DRAIN: continue counting. At boundary (cnt==period-1): go to IDLE, clk_out=0. If en returns to 1 first, go back to RUN with no discontinuity.
- Latency: en rising sampled at edge t with phase=0 gives clk_out=1 after edge t+1, provided high>0. With phase=P, the first high occurs P cycles later.
- Duty edge cases:
  - high=0: clk_out stays 0 while running.
  - high>=period: clk_out stays 1 for the whole of RUN.
  - period=1 with high>=1: constant 1.
- Channels are fully independent; simultaneous en edges on multiple channels are handled in the same cycle.
- cfg_wr to a channel on the same edge as its boundary: the boundary uses the old shadow; the new write becomes pending for the next boundary.
- Async reset mid-operation forces all reset values immediately. Config returns to defaults.
- active = (state != IDLE).

Test Plan:
- Reset, then en[0]=1 with defaults -> clk_out[0] toggles 1,0,1,0 starting the cycle after en; active[0]=1.
- Write ch1 period=5, high=2, phase=3, then en[1]=1 -> 3 low cycles, then repeating pattern 1,1,0,0,0; ch0 unaffected.
- While ch0 runs period=4/high=2, write period=6/high=3 at cnt=1 -> current period finishes as 4 cycles; next period is 1,1,1,0,0,0.
- ch0 period=8/high=4, drop en at cnt=2 -> full period completes, clk_out=0, active=0 at the boundary. Re-raising en at cnt=5 keeps running with no gap.
- Write period=0, and separately phase=4/period=4, and separately cfg_ch=2 with NUM_CH=2 -> cfg_err pulses once per write; config unchanged.
- Assert rst_n=0 mid-RUN on both channels -> clk_out=0, active=0 immediately. After release, a channel runs divide-by-2 again on en.

Source files
------------

// File: rtl/clk_gen_multi.sv
// ---------------------------------------------------------------------------
// clk_gen_multi
//   Multi-channel programmable clock-enable / strobe generator. Each channel
//   produces a registered waveform with a runtime-programmable period, high
//   count and start phase. Start and stop are glitch-free, and new settings
//   take effect only at a period boundary or while the channel is idle.
//   Outputs are intended for downstream timing logic, not as a clock net.
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   en         per-channel run request (level)
//   cfg_wr     one-cycle configuration write strobe
//   cfg_ch     channel targeted by cfg_wr
//   cfg_period period in clk cycles (must be non-zero)
//   cfg_high   clk cycles high per period
//   cfg_phase  start delay after en rises (must be below cfg_period)
//   cfg_err    one-cycle pulse when the previous cfg_wr was rejected
//   clk_out    generated waveforms, registered
//   active     channel is waiting on its phase, running or draining
// ---------------------------------------------------------------------------
module clk_gen_multi #(
    parameter int NUM_CH = 2,
    parameter int CNT_W  = 8,
    parameter int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] en,
    input  logic              cfg_wr,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [CNT_W-1:0]  cfg_period,
    input  logic [CNT_W-1:0]  cfg_high,
    input  logic [CNT_W-1:0]  cfg_phase,
    output logic              cfg_err,
    output logic [NUM_CH-1:0] clk_out,
    output logic [NUM_CH-1:0] active
);

    typedef enum logic [1:0] {
        IDLE,
        PHASE_WAIT,
        RUN,
        DRAIN
    } ch_state_t;

    // One extra bit so NUM_CH itself is representable when it is a power of two.
    localparam logic [CH_W:0] NUM_CH_V = (CH_W + 1)'(NUM_CH);

    logic cfg_ok;

    // A write is legal only with a non-zero period, a phase that fits inside
    // the period and a channel index that exists.
    assign cfg_ok = (cfg_period != '0) &&
                    (cfg_phase < cfg_period) &&
                    ({1'b0, cfg_ch} < NUM_CH_V);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_err <= 1'b0;
        end else begin
            cfg_err <= cfg_wr && !cfg_ok;
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        ch_state_t        state_q, state_nx;
        logic [CNT_W-1:0] cnt_q, cnt_nx;
        logic [CNT_W-1:0] ph_q, ph_nx;
        logic             out_q, out_nx;
        logic [CNT_W-1:0] act_period_q, act_high_q, act_phase_q;
        logic [CNT_W-1:0] sh_period_q, sh_high_q, sh_phase_q;
        logic             pend_q;
        logic             apply;
        logic             wr_hit;
        logic             wrap;
        logic [CNT_W-1:0] eff_phase;

        assign wr_hit = cfg_wr && cfg_ok && (cfg_ch == CH_W'(i));

        // Next-state logic. RUN and DRAIN share the counting step; DRAIN only
        // differs in that a boundary with en still low ends the waveform, so
        // a stop request never truncates a high pulse. When leaving IDLE the
        // phase decision uses the pending shadow if one is being applied on
        // the same edge, so a write followed by en honours the new phase.
        always_comb begin
            state_nx  = state_q;
            cnt_nx    = cnt_q;
            ph_nx     = ph_q;
            out_nx    = 1'b0;
            apply     = 1'b0;
            wrap      = (cnt_q == act_period_q - 1'b1);
            eff_phase = pend_q ? sh_phase_q : act_phase_q;
            case (state_q)
                IDLE: begin
                    cnt_nx = '0;
                    apply  = pend_q;
                    if (en[i]) begin
                        if (eff_phase != '0) begin
                            state_nx = PHASE_WAIT;
                            ph_nx    = eff_phase - 1'b1;
                        end else begin
                            state_nx = RUN;
                        end
                    end
                end
                PHASE_WAIT: begin
                    if (!en[i]) begin
                        state_nx = IDLE;
                    end else if (ph_q == '0) begin
                        state_nx = RUN;
                        cnt_nx   = '0;
                    end else begin
                        ph_nx = ph_q - 1'b1;
                    end
                end
                RUN, DRAIN: begin
                    if ((state_q == DRAIN) && !en[i] && wrap) begin
                        state_nx = IDLE;
                        cnt_nx   = '0;
                    end else begin
                        out_nx   = (cnt_q < act_high_q);
                        cnt_nx   = wrap ? '0 : cnt_q + 1'b1;
                        apply    = wrap && pend_q;
                        state_nx = en[i] ? RUN : DRAIN;
                    end
                end
                default: begin
                    state_nx = IDLE;
                end
            endcase
        end

        // State, counters and output register.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state_q <= IDLE;
                cnt_q   <= '0;
                ph_q    <= '0;
                out_q   <= 1'b0;
            end else begin
                state_q <= state_nx;
                cnt_q   <= cnt_nx;
                ph_q    <= ph_nx;
                out_q   <= out_nx;
            end
        end

        // Shadow/active configuration. The copy reads the shadow value held
        // before this edge, so a write landing on a boundary stays pending
        // for the following boundary instead of being lost.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                act_period_q <= CNT_W'(2);
                act_high_q   <= CNT_W'(1);
                act_phase_q  <= '0;
                sh_period_q  <= CNT_W'(2);
                sh_high_q    <= CNT_W'(1);
                sh_phase_q   <= '0;
                pend_q       <= 1'b0;
            end else begin
                if (apply) begin
                    act_period_q <= sh_period_q;
                    act_high_q   <= sh_high_q;
                    act_phase_q  <= sh_phase_q;
                end
                if (wr_hit) begin
                    sh_period_q <= cfg_period;
                    sh_high_q   <= cfg_high;
                    sh_phase_q  <= cfg_phase;
                    pend_q      <= 1'b1;
                end else if (apply) begin
                    pend_q <= 1'b0;
                end
            end
        end

        assign clk_out[i] = out_q;
        assign active[i]  = (state_q != IDLE);
    end

endmodule

// File: tb/tb_clk_gen_multi.sv
module tb_clk_gen_multi;

   localparam int NCH = 2;

   logic           clk = 1'b0;
   logic           rst_n = 1'b1;
   logic [NCH-1:0] en = '0;
   logic           cfg_wr = 1'b0;
   logic [1:0]     cfg_ch = '0;
   logic [7:0]     cfg_period = '0;
   logic [7:0]     cfg_high = '0;
   logic [7:0]     cfg_phase = '0;
   logic           cfg_err;
   logic [NCH-1:0] clk_out;
   logic [NCH-1:0] active;

   int total = 0;
   int bad = 0;
   bit chkEn = 1'b0;

   // Model state: whether the waveform is counting, whether a stop was
   // requested, remaining start delay (-1 when not delaying), position in
   // the period, and active / shadow configuration.
   bit mOn[NCH];
   bit mStop[NCH];
   int mDelay[NCH];
   int mPos[NCH];
   bit mOut[NCH];
   int aPer[NCH], aHigh[NCH], aPh[NCH];
   int sPer[NCH], sHigh[NCH], sPh[NCH];
   bit mPend[NCH];
   bit mErr;

   clk_gen_multi #(.NUM_CH(NCH), .CNT_W(8), .CH_W(2)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .en(en),
      .cfg_wr(cfg_wr),
      .cfg_ch(cfg_ch),
      .cfg_period(cfg_period),
      .cfg_high(cfg_high),
      .cfg_phase(cfg_phase),
      .cfg_err(cfg_err),
      .clk_out(clk_out),
      .active(active)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input int actual, input int expected);
      total++;
      if (actual != expected) begin
         bad++;
         $display("[TB] FAIL %s at %0t: got %0d expected %0d", name, $time, actual, expected);
      end
   endtask

   // Reference model: advances on each rising edge from the sampled inputs.
   initial begin
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) begin
            for (int c = 0; c < NCH; c++) begin
               mOn[c] = 0; mStop[c] = 0; mDelay[c] = -1; mPos[c] = 0; mOut[c] = 0;
               aPer[c] = 2; aHigh[c] = 1; aPh[c] = 0;
               sPer[c] = 2; sHigh[c] = 1; sPh[c] = 0;
               mPend[c] = 0;
            end
            mErr = 0;
         end else begin
            for (int c = 0; c < NCH; c++) begin
               if (mOn[c]) begin
                  if (mStop[c] && !en[c] && mPos[c] == aPer[c] - 1) begin
                     mOn[c] = 0; mStop[c] = 0; mOut[c] = 0; mPos[c] = 0;
                  end else begin
                     mOut[c] = (mPos[c] < aHigh[c]);
                     if (mPos[c] == aPer[c] - 1) begin
                        mPos[c] = 0;
                        if (mPend[c]) begin
                           aPer[c] = sPer[c]; aHigh[c] = sHigh[c]; aPh[c] = sPh[c]; mPend[c] = 0;
                        end
                     end else begin
                        mPos[c] = mPos[c] + 1;
                     end
                     mStop[c] = !en[c];
                  end
               end else if (mDelay[c] >= 0) begin
                  mOut[c] = 0;
                  if (!en[c]) mDelay[c] = -1;
                  else if (mDelay[c] == 0) begin mDelay[c] = -1; mOn[c] = 1; mPos[c] = 0; end
                  else mDelay[c] = mDelay[c] - 1;
               end else begin
                  mOut[c] = 0; mPos[c] = 0;
                  if (mPend[c]) begin
                     aPer[c] = sPer[c]; aHigh[c] = sHigh[c]; aPh[c] = sPh[c]; mPend[c] = 0;
                  end
                  if (en[c]) begin
                     if (aPh[c] > 0) mDelay[c] = aPh[c] - 1;
                     else begin mOn[c] = 1; mPos[c] = 0; end
                  end
               end
            end
            mErr = 0;
            if (cfg_wr) begin
               if (cfg_period == 0 || cfg_phase >= cfg_period || int'(cfg_ch) >= NCH) begin
                  mErr = 1;
               end else begin
                  sPer[int'(cfg_ch)] = int'(cfg_period);
                  sHigh[int'(cfg_ch)] = int'(cfg_high);
                  sPh[int'(cfg_ch)] = int'(cfg_phase);
                  mPend[int'(cfg_ch)] = 1;
               end
            end
         end
      end
   end

   // Compare DUT against the model on every falling edge out of reset.
   initial begin
      forever begin
         @(negedge clk);
         if (chkEn && rst_n) begin
            for (int c = 0; c < NCH; c++) begin
               checkOutput($sformatf("model_clk_out[%0d]", c), int'(clk_out[c]), int'(mOut[c]));
               checkOutput($sformatf("model_active[%0d]", c), int'(active[c]),
                           int'(mOn[c] || mDelay[c] >= 0));
            end
            checkOutput("model_cfg_err", int'(cfg_err), int'(mErr));
         end
      end
   end

   task automatic waitCycles(input int n);
      for (int k = 0; k < n; k++) @(negedge clk);
   endtask

   // Drive a config write for one edge; returns on the falling edge after it.
   task automatic applyStimulus(input logic [1:0] ch, input int per, input int high, input int ph);
      cfg_wr = 1'b1;
      cfg_ch = ch;
      cfg_period = 8'(per);
      cfg_high = 8'(high);
      cfg_phase = 8'(ph);
      @(negedge clk);
      cfg_wr = 1'b0;
   endtask

   // Compare n consecutive samples of clk_out[ch] against pat, MSB first.
   task automatic checkBits(input string name, input int ch, input logic [31:0] pat, input int n);
      for (int k = 0; k < n; k++) begin
         @(negedge clk);
         checkOutput($sformatf("%s[%0d]", name, k), int'(clk_out[ch]), int'(pat[n-1-k]));
      end
   endtask

   initial begin
      #2 rst_n = 1'b0;
      waitCycles(2);
      rst_n = 1'b1;
      chkEn = 1'b1;
      checkOutput("reset_clk_out", int'(clk_out), 0);
      checkOutput("reset_active", int'(active), 0);
      checkOutput("reset_cfg_err", int'(cfg_err), 0);

      // Defaults: divide-by-2 starting the cycle after en.
      en[0] = 1'b1;
      checkBits("div2", 0, 32'b01010, 5);
      checkOutput("div2_active", int'(active[0]), 1);

      // ch1 period 5, high 2, phase 3.
      applyStimulus(2'd1, 5, 2, 3);
      en[1] = 1'b1;
      checkBits("ch1_phase", 1, 32'b00001100011000, 14);
      en = '0;
      waitCycles(20);

      // Reconfigure mid-period: 4/2 finishes, then 6/3.
      applyStimulus(2'd0, 4, 2, 0);
      en[0] = 1'b1;
      checkBits("reconf_a", 0, 32'b01, 2);
      cfg_wr = 1'b1; cfg_ch = 2'd0; cfg_period = 8'd6; cfg_high = 8'd3; cfg_phase = 8'd0;
      @(negedge clk);
      cfg_wr = 1'b0;
      checkOutput("reconf_mid", int'(clk_out[0]), 1);
      checkBits("reconf_b", 0, 32'b00111000, 8);
      en[0] = 1'b0;
      waitCycles(12);

      // Drain: period 8 high 4, en dropped at cnt=2.
      applyStimulus(2'd0, 8, 4, 0);
      en[0] = 1'b1;
      checkBits("drain_a", 0, 32'b011, 3);
      en[0] = 1'b0;
      checkBits("drain_b", 0, 32'b11000, 5);
      checkOutput("drain_active_before", int'(active[0]), 1);
      @(negedge clk);
      checkOutput("drain_end_out", int'(clk_out[0]), 0);
      checkOutput("drain_end_active", int'(active[0]), 0);

      // Re-raise en at cnt=5 during drain: no gap.
      en[0] = 1'b1;
      checkBits("rerun_a", 0, 32'b011, 3);
      en[0] = 1'b0;
      checkBits("rerun_b", 0, 32'b110, 3);
      en[0] = 1'b1;
      checkBits("rerun_c", 0, 32'b0001111, 7);

      // Rejected writes.
      applyStimulus(2'd0, 0, 1, 0);
      checkOutput("err_period0", int'(cfg_err), 1);
      @(negedge clk);
      checkOutput("err_clear", int'(cfg_err), 0);
      applyStimulus(2'd0, 4, 1, 4);
      checkOutput("err_phase", int'(cfg_err), 1);
      applyStimulus(2'd2, 5, 2, 1);
      checkOutput("err_chan", int'(cfg_err), 1);
      applyStimulus(2'd1, 3, 1, 0);
      checkOutput("err_valid_write", int'(cfg_err), 0);
      waitCycles(16);

      // Async reset mid-run on both channels.
      en = 2'b11;
      waitCycles(10);
      checkOutput("pre_reset_active", int'(active), 3);
      #2 rst_n = 1'b0;
      #1;
      checkOutput("async_clk_out", int'(clk_out), 0);
      checkOutput("async_active", int'(active), 0);
      en = '0;
      waitCycles(2);
      rst_n = 1'b1;
      en[0] = 1'b1;
      checkBits("post_reset_div2", 0, 32'b01010, 5);
      en = '0;
      waitCycles(6);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
